// File: rtl/zreg_sequencer_if.sv
// Instruction handshake and single-port register-file bus of the zreg sequencer.
// The slave modport is the sequencer; master is the instruction source plus register file.
interface zreg_sequencer_if;
    logic       INSTR_VALID;
    logic       INSTR_READY;
    logic [1:0] INSTR_OP;
    logic [1:0] INSTR_DST;
    logic [1:0] INSTR_SRC;
    logic [7:0] INSTR_IMM;
    logic [7:0] RF_IN;
    logic       RF_OPCODE;
    logic [1:0] RF_REG_SEL;
    logic [7:0] RF_OUT;

    modport slave (
        input  INSTR_VALID, INSTR_OP, INSTR_DST, INSTR_SRC, INSTR_IMM, RF_OUT,
        output INSTR_READY, RF_IN, RF_OPCODE, RF_REG_SEL
    );

    modport master (
        output INSTR_VALID, INSTR_OP, INSTR_DST, INSTR_SRC, INSTR_IMM, RF_OUT,
        input  INSTR_READY, RF_IN, RF_OPCODE, RF_REG_SEL
    );
endinterface

// File: rtl/zreg_sequencer.sv
// Multi-cycle LDI/MOV/ADD/SUB sequencer that serialises operand reads and the
// result write onto the single port of a 4x8-bit register file.
module zreg_sequencer (
    input  logic            CLK,
    input  logic            RST_N,
    zreg_sequencer_if.slave BUS,
    output logic            BUSY,
    output logic            DONE,
    output logic [7:0]      RESULT,
    output logic            ZERO,
    output logic            CARRY
);
    typedef enum logic [1:0] {S_IDLE, S_RD_A, S_RD_B, S_WR} state_t;
    typedef enum logic [1:0] {OP_LDI = 2'b00, OP_MOV = 2'b01, OP_ADD = 2'b10, OP_SUB = 2'b11} op_t;

    state_t     r_state;
    state_t     w_next;
    op_t        r_op;
    logic [1:0] r_dst;
    logic [1:0] r_src;
    logic [7:0] r_imm;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [7:0] r_result;
    logic       r_zero;
    logic       r_carry;
    logic       r_done;

    logic       w_handshake;
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic [7:0] w_result;
    logic       w_carry;

    // Bit 8 of the 9-bit difference is the borrow (A < B).
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        case (r_op)
            OP_LDI: w_result = r_imm;
            OP_MOV: w_result = r_a;
            OP_ADD: begin
                w_result = w_sum[7:0];
                w_carry  = w_sum[8];
            end
            OP_SUB: begin
                w_result = w_diff[7:0];
                w_carry  = w_diff[8];
            end
            default: w_result = '0;
        endcase
    end

    assign BUS.INSTR_READY = (r_state == S_IDLE) && RST_N;
    assign w_handshake     = BUS.INSTR_VALID && BUS.INSTR_READY;
    assign BUSY            = (r_state != S_IDLE) && RST_N;

    always_ff @(posedge CLK) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        BUS.RF_OPCODE  = 1'b0;
        BUS.RF_REG_SEL = '0;
        BUS.RF_IN      = '0;
        case (r_state)
            S_IDLE: begin
                if (w_handshake) w_next = (op_t'(BUS.INSTR_OP) == OP_LDI) ? S_WR : S_RD_A;
            end
            S_RD_A: begin
                BUS.RF_REG_SEL = (r_op == OP_MOV) ? r_src : r_dst;
                w_next         = (r_op == OP_MOV) ? S_WR : S_RD_B;
            end
            S_RD_B: begin
                BUS.RF_REG_SEL = r_src;
                w_next         = S_WR;
            end
            S_WR: begin
                // Reset gates the strobe so an in-flight write is aborted.
                BUS.RF_OPCODE  = RST_N;
                BUS.RF_REG_SEL = r_dst;
                BUS.RF_IN      = w_result;
                w_next         = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_op     <= OP_LDI;
            r_dst    <= '0;
            r_src    <= '0;
            r_imm    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_WR);
            case (r_state)
                S_IDLE: begin
                    if (w_handshake) begin
                        r_op  <= op_t'(BUS.INSTR_OP);
                        r_dst <= BUS.INSTR_DST;
                        r_src <= BUS.INSTR_SRC;
                        r_imm <= BUS.INSTR_IMM;
                    end
                end
                S_RD_A: r_a <= BUS.RF_OUT;
                S_RD_B: r_b <= BUS.RF_OUT;
                S_WR: begin
                    r_result <= w_result;
                    if (r_op == OP_ADD || r_op == OP_SUB) begin
                        r_zero  <= (w_result == 8'h00);
                        r_carry <= w_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign DONE   = r_done;
    assign RESULT = r_result;
    assign ZERO   = r_zero;
    assign CARRY  = r_carry;
endmodule

// File: tb/tb_zreg_sequencer.sv
// Self-checking bench for zreg_sequencer: a behavioural register file on the bus
// and an instruction-level reference model of registers, result and flags.
module tb_zreg_sequencer;
    logic       CLK = 1'b0;
    logic       RST_N;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RESULT;
    logic       ZERO;
    logic       CARRY;

    zreg_sequencer_if bus();

    zreg_sequencer dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .BUS    (bus),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT),
        .ZERO   (ZERO),
        .CARRY  (CARRY)
    );

    always #5 CLK = ~CLK;

    logic [7:0]  rf [4] = '{default: 8'h00};
    int unsigned wr_count = 0;

    assign bus.RF_OUT = rf[bus.RF_REG_SEL];

    always @(posedge CLK) begin
        if (bus.RF_OPCODE === 1'b1) begin
            rf[bus.RF_REG_SEL] <= bus.RF_IN;
            wr_count <= wr_count + 1;
        end
    end

    int unsigned m_rf [4];
    int unsigned m_result;
    bit          m_zero;
    bit          m_carry;

    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.INSTR_VALID = 1'b0;
        bus.INSTR_OP    = 2'($urandom);
        bus.INSTR_DST   = 2'($urandom);
        bus.INSTR_SRC   = 2'($urandom);
        bus.INSTR_IMM   = 8'($urandom);
    endtask

    // Issues one instruction at the current (idle) cycle and follows it to its DONE cycle.
    task automatic exec(input int op, input int dst, input int src, input int imm, input bit hold);
        int unsigned val;
        int unsigned a;
        int unsigned b;
        bit          is_alu;
        bit          carry;
        int          lat;
        int          nrd;
        int          rd [2];
        int unsigned wc0;

        a      = m_rf[dst];
        b      = m_rf[src];
        is_alu = (op >= 2);
        carry  = 1'b0;
        nrd    = 0;
        case (op)
            0: begin val = imm; lat = 2; end
            1: begin val = m_rf[src]; lat = 3; rd[0] = src; nrd = 1; end
            2: begin val = (a + b) % 256; carry = (a + b) > 255; lat = 4; rd[0] = dst; rd[1] = src; nrd = 2; end
            default: begin val = (a + 256 - b) % 256; carry = (a < b); lat = 4; rd[0] = dst; rd[1] = src; nrd = 2; end
        endcase
        m_rf[dst] = val;
        m_result  = val;
        if (is_alu) begin
            m_zero  = (val == 0);
            m_carry = carry;
        end

        bus.INSTR_VALID = 1'b1;
        bus.INSTR_OP    = 2'(op);
        bus.INSTR_DST   = 2'(dst);
        bus.INSTR_SRC   = 2'(src);
        bus.INSTR_IMM   = 8'(imm);
        wc0 = wr_count;
        checks++; if (bus.INSTR_READY !== 1'b1) begin errors++; $display("FAIL ready_issue got %b exp 1", bus.INSTR_READY); end

        for (int cyc = 1; cyc <= lat; cyc++) begin
            step();
            if (hold && cyc < lat) begin
                bus.INSTR_OP  = 2'($urandom);
                bus.INSTR_DST = 2'($urandom);
                bus.INSTR_SRC = 2'($urandom);
                bus.INSTR_IMM = 8'($urandom);
            end else begin
                idle_inputs();
            end
            #1;
            if (cyc < lat) begin
                checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL busy op%0d c%0d got %b exp 1", op, cyc, BUSY); end
                checks++; if (bus.INSTR_READY !== 1'b0) begin errors++; $display("FAIL ready_busy op%0d c%0d got %b exp 0", op, cyc, bus.INSTR_READY); end
                checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL done_early op%0d c%0d got %b exp 0", op, cyc, DONE); end
            end
            if (cyc <= nrd) begin
                checks++; if (bus.RF_OPCODE !== 1'b0) begin errors++; $display("FAIL rd_opcode op%0d c%0d got %b exp 0", op, cyc, bus.RF_OPCODE); end
                checks++; if (bus.RF_REG_SEL !== 2'(rd[cyc-1])) begin errors++; $display("FAIL rd_sel op%0d c%0d got %0d exp %0d", op, cyc, bus.RF_REG_SEL, rd[cyc-1]); end
            end
            if (cyc == lat - 1) begin
                checks++; if (bus.RF_OPCODE !== 1'b1) begin errors++; $display("FAIL wr_opcode op%0d got %b exp 1", op, bus.RF_OPCODE); end
                checks++; if (bus.RF_REG_SEL !== 2'(dst)) begin errors++; $display("FAIL wr_sel op%0d got %0d exp %0d", op, bus.RF_REG_SEL, dst); end
                checks++; if (bus.RF_IN !== 8'(val)) begin errors++; $display("FAIL wr_data op%0d got %h exp %h", op, bus.RF_IN, 8'(val)); end
            end
            if (cyc == lat) begin
                checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL done op%0d got %b exp 1", op, DONE); end
                checks++; if (bus.INSTR_READY !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL idle_after op%0d ready %b busy %b exp 1 0", op, bus.INSTR_READY, BUSY); end
                checks++; if (RESULT !== 8'(m_result)) begin errors++; $display("FAIL result op%0d got %h exp %h", op, RESULT, 8'(m_result)); end
                checks++; if (ZERO !== m_zero || CARRY !== m_carry) begin errors++; $display("FAIL flags op%0d got z%b c%b exp z%b c%b", op, ZERO, CARRY, m_zero, m_carry); end
                checks++; if (wr_count !== wc0 + 1) begin errors++; $display("FAIL wr_count op%0d got %0d exp %0d", op, wr_count, wc0 + 1); end
                checks++; if (rf[dst] !== 8'(m_rf[dst])) begin errors++; $display("FAIL rf_dst op%0d R%0d got %h exp %h", op, dst, rf[dst], 8'(m_rf[dst])); end
            end
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        idle_inputs();
        step();
        step();
        checks++; if (bus.INSTR_READY !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL rst_low ready %b busy %b exp 0 0", bus.INSTR_READY, BUSY); end
        checks++; if (bus.RF_OPCODE !== 1'b0) begin errors++; $display("FAIL rst_opcode got %b exp 0", bus.RF_OPCODE); end
        RST_N = 1'b1;
        #1;
        checks++; if (bus.INSTR_READY !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.INSTR_READY); end
        checks++; if (RESULT !== 8'h00 || ZERO !== 1'b0 || CARRY !== 1'b0 || DONE !== 1'b0) begin errors++; $display("FAIL rst_outputs got r%h z%b c%b d%b exp 00 0 0 0", RESULT, ZERO, CARRY, DONE); end
        checks++; if (bus.RF_REG_SEL !== 2'b00 || bus.RF_IN !== 8'h00) begin errors++; $display("FAIL rst_bus sel %0d in %h exp 0 00", bus.RF_REG_SEL, bus.RF_IN); end
        for (int i = 0; i < 4; i++) m_rf[i] = 0;
        m_result = 0;
        m_zero   = 1'b0;
        m_carry  = 1'b0;
    endtask

    task automatic test_ldi_back_to_back();
        exec(0, 0, 0, 'hAA, 1'b0);
        exec(0, 1, 2, 'hCC, 1'b0);
        exec(0, 2, 3, 'hF0, 1'b0);
        exec(0, 3, 1, 'h0F, 1'b0);
        checks++; if (rf[0] !== 8'hAA || rf[1] !== 8'hCC || rf[2] !== 8'hF0 || rf[3] !== 8'h0F) begin errors++; $display("FAIL ldi_readback got %h %h %h %h exp AA CC F0 0F", rf[0], rf[1], rf[2], rf[3]); end
    endtask

    task automatic test_mov();
        exec(1, 3, 0, 0, 1'b0);
        checks++; if (rf[3] !== 8'hAA) begin errors++; $display("FAIL mov_r3 got %h exp AA", rf[3]); end
    endtask

    task automatic test_alu();
        exec(0, 1, 0, 'hF0, 1'b0);
        exec(0, 2, 0, 'h20, 1'b0);
        exec(2, 1, 2, 0, 1'b0);
        checks++; if (rf[1] !== 8'h10 || CARRY !== 1'b1 || ZERO !== 1'b0) begin errors++; $display("FAIL add_f0_20 got %h c%b z%b exp 10 1 0", rf[1], CARRY, ZERO); end
        exec(3, 1, 1, 0, 1'b0);
        checks++; if (rf[1] !== 8'h00 || CARRY !== 1'b0 || ZERO !== 1'b1) begin errors++; $display("FAIL sub_self got %h c%b z%b exp 00 0 1", rf[1], CARRY, ZERO); end
        exec(0, 2, 0, 'h05, 1'b0);
        exec(0, 3, 0, 'h07, 1'b0);
        exec(3, 2, 3, 0, 1'b0);
        checks++; if (rf[2] !== 8'hFE || CARRY !== 1'b1 || ZERO !== 1'b0) begin errors++; $display("FAIL sub_borrow got %h c%b z%b exp FE 1 0", rf[2], CARRY, ZERO); end
        exec(2, 0, 0, 0, 1'b0);
    endtask

    task automatic test_valid_hold();
        exec(2, 0, 1, 0, 1'b1);
        exec(1, 2, 0, 0, 1'b1);
        exec(0, 1, 0, 'h5A, 1'b1);
        exec(3, 3, 2, 0, 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                step();
                idle_inputs();
                #1;
                checks++; if (DONE !== 1'b0 || bus.INSTR_READY !== 1'b1 || bus.RF_OPCODE !== 1'b0) begin errors++; $display("FAIL gap done %b ready %b op %b exp 0 1 0", DONE, bus.INSTR_READY, bus.RF_OPCODE); end
            end
            exec(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid();
        int unsigned wc;
        exec(0, 0, 0, int'($urandom_range(1, 255)), 1'b0);
        exec(0, 1, 0, int'($urandom_range(1, 255)), 1'b0);
        bus.INSTR_VALID = 1'b1;
        bus.INSTR_OP    = 2'd2;
        bus.INSTR_DST   = 2'd0;
        bus.INSTR_SRC   = 2'd1;
        step(); idle_inputs();
        step();
        step();
        checks++; if (bus.RF_OPCODE !== 1'b1) begin errors++; $display("FAIL mid_wr_before got %b exp 1", bus.RF_OPCODE); end
        RST_N = 1'b0;
        #1;
        checks++; if (bus.RF_OPCODE !== 1'b0 || bus.INSTR_READY !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL mid_rst_comb op %b ready %b busy %b exp 0 0 0", bus.RF_OPCODE, bus.INSTR_READY, BUSY); end
        wc = wr_count;
        step();
        checks++; if (rf[0] !== 8'(m_rf[0]) || wr_count !== wc) begin errors++; $display("FAIL mid_abort r0 %h writes %0d exp %h %0d", rf[0], wr_count, 8'(m_rf[0]), wc); end
        checks++; if (DONE !== 1'b0 || RESULT !== 8'h00 || ZERO !== 1'b0 || CARRY !== 1'b0) begin errors++; $display("FAIL mid_rst_regs d%b r%h z%b c%b exp 0 00 0 0", DONE, RESULT, ZERO, CARRY); end
        RST_N = 1'b1;
        step();
        checks++; if (bus.INSTR_READY !== 1'b1 || DONE !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL mid_release ready %b done %b busy %b exp 1 0 0", bus.INSTR_READY, DONE, BUSY); end
        m_result = 0;
        m_zero   = 1'b0;
        m_carry  = 1'b0;
        exec(2, 0, 1, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_ldi_back_to_back();
        test_mov();
        test_alu();
        test_valid_hold();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end
endmodule
